// File: rtl/bus_src_arbiter_pkg.sv
// Shared types and defaults for the register-bus source arbiter.
// State codes, default geometry and the existing register width live here.
package bus_src_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_TURN  = 2'd2
  } arb_state_e;

  localparam int unsigned DEF_NUM_REQ   = 16;
  localparam int unsigned DEF_SEL_WIDTH = 4;
  localparam int unsigned REG_WIDTH     = 32;

  // Hold counter only needs to reach MAX_HOLD-1, so this never wraps.
  function automatic int unsigned arb_hold_width(input int unsigned max_hold);
    return $clog2(max_hold) + 1;
  endfunction

endpackage

// File: rtl/bus_src_arbiter_if.sv
// Requester-side handshake bundle for the source arbiter.
// master = requesters/mux consumer, slave = arbiter.
interface bus_src_arbiter_if
  import bus_src_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ   = DEF_NUM_REQ,
    parameter int unsigned SEL_WIDTH = DEF_SEL_WIDTH
);

    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ-1:0]   gnt;
    logic [SEL_WIDTH-1:0] selector;
    logic                 bus_valid;
    logic                 timeout;

    modport master (
        output req,
        input  gnt,
        input  selector,
        input  bus_valid,
        input  timeout
    );

    modport slave (
        input  req,
        output gnt,
        output selector,
        output bus_valid,
        output timeout
    );

endinterface

// File: rtl/bus_src_arbiter_rr_pick.sv
// Combinational round-robin pick: first request above last_ptr, wrapping.
// The request vector is doubled so the wrap becomes a plain windowed scan.
module arb_rr_pick
  import bus_src_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ   = DEF_NUM_REQ,
    parameter int unsigned SEL_WIDTH = DEF_SEL_WIDTH
) (
    input  logic [NUM_REQ-1:0]   i_req,
    input  logic [SEL_WIDTH-1:0] i_last_ptr,
    output logic                 o_any,
    output logic [SEL_WIDTH-1:0] o_winner
);

    logic [2*NUM_REQ-1:0] w_dbl;
    logic [31:0]          w_lp;

    assign w_dbl = {i_req, i_req};
    assign w_lp  = 32'(i_last_ptr);

    // Window (last_ptr, last_ptr+NUM_REQ] covers every index exactly once.
    always_comb begin
        o_any    = 1'b0;
        o_winner = '0;
        for (int unsigned k = 0; k < 2 * NUM_REQ; k++) begin
            if (!o_any && w_dbl[k] && (k > w_lp) && (k <= w_lp + NUM_REQ)) begin
                o_any    = 1'b1;
                o_winner = SEL_WIDTH'(k % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/bus_src_arbiter.sv
// Round-robin arbiter for the 16:1 register-bus source mux, with a hold
// timer bounding ownership and one turnaround cycle between owners.
module bus_src_arbiter
  import bus_src_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ   = DEF_NUM_REQ,
    parameter int unsigned SEL_WIDTH = DEF_SEL_WIDTH,
    parameter int unsigned MAX_HOLD  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    bus_src_arbiter_if.slave   bus
);

    localparam int unsigned        HCW       = arb_hold_width(MAX_HOLD);
    localparam logic [HCW-1:0]     HOLD_LAST = HCW'(MAX_HOLD - 1);
    localparam logic [SEL_WIDTH-1:0] PTR_INIT = SEL_WIDTH'(NUM_REQ - 1);

    arb_state_e           r_state, w_next_state;
    logic [HCW-1:0]       r_hold_cnt, w_hold_cnt_nxt;
    logic [SEL_WIDTH-1:0] r_last_ptr, w_last_ptr_nxt;
    logic [SEL_WIDTH-1:0] r_sel, w_sel_nxt;
    logic                 r_bus_valid, w_bus_valid_nxt;
    logic                 r_timeout, w_timeout_nxt;

    logic                 w_any;
    logic [SEL_WIDTH-1:0] w_winner;
    logic                 w_owner_req;
    logic                 w_expired;
    logic [NUM_REQ-1:0]   w_gnt;

    arb_rr_pick #(
        .NUM_REQ  (NUM_REQ),
        .SEL_WIDTH(SEL_WIDTH)
    ) u_pick (
        .i_req     (bus.req),
        .i_last_ptr(r_last_ptr),
        .o_any     (w_any),
        .o_winner  (w_winner)
    );

    assign w_owner_req = bus.req[r_sel];
    assign w_expired   = (r_hold_cnt == HOLD_LAST);

    always_comb begin
        w_next_state    = r_state;
        w_hold_cnt_nxt  = r_hold_cnt;
        w_last_ptr_nxt  = r_last_ptr;
        w_sel_nxt       = r_sel;
        w_bus_valid_nxt = r_bus_valid;
        w_timeout_nxt   = 1'b0;
        case (r_state)
            ARB_IDLE, ARB_TURN: begin
                w_bus_valid_nxt = 1'b0;
                if (w_any) begin
                    w_next_state    = ARB_GRANT;
                    w_sel_nxt       = w_winner;
                    w_bus_valid_nxt = 1'b1;
                    w_hold_cnt_nxt  = '0;
                end else begin
                    w_next_state = ARB_IDLE;
                end
            end
            ARB_GRANT: begin
                if (!w_owner_req || w_expired) begin
                    w_next_state    = ARB_TURN;
                    w_bus_valid_nxt = 1'b0;
                    w_last_ptr_nxt  = r_sel;
                    // Only a still-requesting owner counts as force-released.
                    w_timeout_nxt   = w_owner_req;
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt + 1'b1;
                end
            end
            default: begin
                w_next_state    = ARB_IDLE;
                w_bus_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ARB_IDLE;
            r_hold_cnt  <= '0;
            r_last_ptr  <= PTR_INIT;
            r_sel       <= '0;
            r_bus_valid <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_hold_cnt  <= w_hold_cnt_nxt;
            r_last_ptr  <= w_last_ptr_nxt;
            r_sel       <= w_sel_nxt;
            r_bus_valid <= w_bus_valid_nxt;
            r_timeout   <= w_timeout_nxt;
        end
    end

    always_comb begin
        w_gnt = '0;
        if (r_bus_valid) begin
            w_gnt[r_sel] = 1'b1;
        end
    end

    assign bus.gnt       = w_gnt;
    assign bus.selector  = r_sel;
    assign bus.bus_valid = r_bus_valid;
    assign bus.timeout   = r_timeout;

endmodule
